// File: rtl/div_unit_pkg.sv
// Shared MIPS definitions for the iterative divider: FSM states, default
// operand width and the R-type function codes that select DIV / DIVU.
package div_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int unsigned DIV_LEN = 32;

    localparam logic [5:0] FUNCT_DIV  = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU = 6'h1B;

endpackage

// File: rtl/div_unit_step.sv
// One restoring-division iteration: shift in the next dividend bit and keep
// the trial difference only when it does not go negative.
module div_step #(
    parameter int unsigned len = 32
) (
    input  logic [len-1:0] rem,
    input  logic           dvd_msb,
    input  logic [len-1:0] divisor,
    output logic [len-1:0] rem_next,
    output logic           q_bit
);

    logic [len:0] shifted;
    logic [len:0] diff;

    // Trial subtraction in len+1 bits; the top bit is the sign of the result
    always_comb begin
        shifted  = {rem, dvd_msb};
        diff     = shifted - {1'b0, divisor};
        q_bit    = ~diff[len];
        rem_next = q_bit ? diff[len-1:0] : shifted[len-1:0];
    end

endmodule

// File: rtl/div_unit.sv
// Iterative DIV/DIVU unit: one quotient bit per clock, quotient to LO,
// remainder to HI, start/busy/done handshake for the hazard unit.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int unsigned len = DIV_LEN
) (
    input  logic           i_clk,
    input  logic           i_reset,
    input  logic           i_start,
    input  logic           i_signed,
    input  logic [len-1:0] i_dividend,
    input  logic [len-1:0] i_divisor,
    output logic           o_busy,
    output logic           o_done,
    output logic [len-1:0] o_quotient,
    output logic [len-1:0] o_remainder
);

    localparam int unsigned CW = $clog2(len);

    div_state_t     state, state_next;
    logic [CW-1:0]  count;
    logic [len-1:0] rem;
    logic [len-1:0] dvd;
    logic [len-1:0] dsr;
    logic           neg_q, neg_r;

    logic [len-1:0] step_rem;
    logic           step_q;
    logic [len-1:0] q_mag;
    logic           dvd_neg, dsr_neg, dsr_zero;
    logic           busy_d, done_d;

    div_step #(.len(len)) u_step (
        .rem      (rem),
        .dvd_msb  (dvd[len-1]),
        .divisor  (dsr),
        .rem_next (step_rem),
        .q_bit    (step_q)
    );

    // Operand sign decode and the quotient value after the current iteration
    always_comb begin
        dvd_neg  = i_signed & i_dividend[len-1];
        dsr_neg  = i_signed & i_divisor[len-1];
        dsr_zero = (i_divisor == '0);
        q_mag    = {dvd[len-2:0], step_q};
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_reset) state <= IDLE;
        else          state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_start) state_next = RUN;
            RUN:     if (count == '0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs derived from the upcoming state, then registered
    always_comb begin
        busy_d = (state_next != IDLE);
        done_d = (state_next == DONE);
    end

    // Registered handshake flags
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            o_busy <= 1'b0;
            o_done <= 1'b0;
        end else begin
            o_busy <= busy_d;
            o_done <= done_d;
        end
    end

    // Operand capture, iteration datapath and result registers
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            count       <= '0;
            rem         <= '0;
            dvd         <= '0;
            dsr         <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            o_quotient  <= '0;
            o_remainder <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        count <= CW'(len - 1);
                        rem   <= '0;
                        if (dsr_zero) begin
                            // Divide by zero runs as unsigned on the raw dividend:
                            // every trial succeeds, giving q = all ones, r = dividend.
                            dvd   <= i_dividend;
                            dsr   <= '0;
                            neg_q <= 1'b0;
                            neg_r <= 1'b0;
                        end else begin
                            dvd   <= dvd_neg ? -i_dividend : i_dividend;
                            dsr   <= dsr_neg ? -i_divisor  : i_divisor;
                            neg_q <= dvd_neg ^ dsr_neg;
                            neg_r <= dvd_neg;
                        end
                    end
                end
                RUN: begin
                    rem <= step_rem;
                    dvd <= q_mag;
                    if (count != '0) begin
                        count <= count - CW'(1);
                    end else begin
                        // Sign fix-up is folded into the final iteration edge so the
                        // registered results are already valid while in DONE.
                        o_quotient  <= neg_q ? -q_mag : q_mag;
                        o_remainder <= neg_r ? -step_rem : step_rem;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: vector table plus handshake/reset sequences.
module tb_div_unit;

    logic        clk;
    logic        i_reset;
    logic        i_start;
    logic        i_signed;
    logic [31:0] i_dividend;
    logic [31:0] i_divisor;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_quotient;
    logic [31:0] o_remainder;

    int total;
    int bad;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
    } vec_t;

    vec_t vecs[14];

    div_unit #(.len(32)) dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_start     (i_start),
        .i_signed    (i_signed),
        .i_dividend  (i_dividend),
        .i_divisor   (i_divisor),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_quotient  (o_quotient),
        .o_remainder (o_remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Called at a negedge: issues a start, optionally re-pulses start at
    // cycle pulse_at, returns at the negedge where o_done is seen.
    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           input int pulse_at,
                           output logic [31:0] q, output logic [31:0] r,
                           output int lat, output int busy_n);
        i_signed   = sgn;
        i_dividend = a;
        i_divisor  = b;
        i_start    = 1'b1;
        lat        = 0;
        busy_n     = 0;
        @(negedge clk);
        i_start    = 1'b0;
        i_signed   = ~sgn;
        i_dividend = $urandom;
        i_divisor  = $urandom;
        for (int n = 1; n <= 60; n++) begin
            if (o_busy) busy_n++;
            if (o_done) begin
                lat = n;
                break;
            end
            if (n == pulse_at) begin
                i_start    = 1'b1;
                i_signed   = 1'b0;
                i_dividend = 32'd45;
                i_divisor  = 32'd9;
            end else begin
                i_start = 1'b0;
            end
            @(negedge clk);
        end
        i_start = 1'b0;
        q = o_quotient;
        r = o_remainder;
    endtask

    initial begin
        logic [31:0] q, r;
        int lat, busy_n, dones;

        total = 0;
        bad   = 0;

        vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
        vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF};
        vecs[2]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1};
        vecs[3]  = '{1'b1, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678};
        vecs[4]  = '{1'b0, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678};
        vecs[5]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0};
        vecs[6]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000};
        vecs[7]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0};
        vecs[8]  = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF};
        vecs[9]  = '{1'b0, 32'd45,         32'd9,          32'd5,          32'd0};
        vecs[10] = '{1'b1, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF9};
        vecs[11] = '{1'b0, 32'hDEAD_BEEF,  32'h10,         32'h0DEA_DBEE,  32'hF};
        vecs[12] = '{1'b1, 32'h8000_0000,  32'd2,          32'hC000_0000,  32'd0};
        vecs[13] = '{1'b0, 32'd5,          32'd7,          32'd0,          32'd5};

        i_reset    = 1'b0;
        i_start    = 1'b0;
        i_signed   = 1'b0;
        i_dividend = '0;
        i_divisor  = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_done", {31'd0, o_done}, 32'd0);
        chk("rst_q", o_quotient, 32'd0);
        chk("rst_r", o_remainder, 32'd0);
        i_reset = 1'b1;
        @(negedge clk);

        // Each vector starts in the first IDLE cycle after the previous DONE
        for (int i = 0; i < 14; i++) begin
            run_div(vecs[i].sgn, vecs[i].a, vecs[i].b, 0, q, r, lat, busy_n);
            chk($sformatf("vec%0d_q", i), q, vecs[i].q);
            chk($sformatf("vec%0d_r", i), r, vecs[i].r);
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd33);
            chk($sformatf("vec%0d_busyn", i), 32'(busy_n), 32'd33);
            @(negedge clk);
            chk($sformatf("vec%0d_idle_busy", i), {31'd0, o_busy}, 32'd0);
            chk($sformatf("vec%0d_idle_done", i), {31'd0, o_done}, 32'd0);
            chk($sformatf("vec%0d_hold_q", i), o_quotient, vecs[i].q);
        end

        // Start pulsed during RUN with other operands must be ignored
        run_div(1'b0, 32'd100, 32'd7, 5, q, r, lat, busy_n);
        chk("ign_q", q, 32'd14);
        chk("ign_r", r, 32'd2);
        chk("ign_lat", 32'(lat), 32'd33);
        dones = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (o_done) dones++;
        end
        chk("ign_no_second_done", 32'(dones), 32'd0);
        chk("ign_idle_busy", {31'd0, o_busy}, 32'd0);

        // Reset during RUN discards the operation
        i_signed   = 1'b0;
        i_dividend = 32'd100;
        i_divisor  = 32'd7;
        i_start    = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre_rst_busy", {31'd0, o_busy}, 32'd1);
        i_reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", {31'd0, o_busy}, 32'd0);
        chk("mid_rst_done", {31'd0, o_done}, 32'd0);
        chk("mid_rst_q", o_quotient, 32'd0);
        chk("mid_rst_r", o_remainder, 32'd0);
        i_reset = 1'b1;
        dones = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (o_done || o_busy) dones++;
        end
        chk("mid_rst_no_done", 32'(dones), 32'd0);
        run_div(1'b0, 32'd45, 32'd9, 0, q, r, lat, busy_n);
        chk("post_rst_q", q, 32'd5);
        chk("post_rst_r", r, 32'd0);
        chk("post_rst_lat", 32'(lat), 32'd33);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
